// File: rtl/cook_time_entry_if.sv
// Panel-side bundle between the debounced front-panel buttons and the cook-time controller.
// Latency: none, pure wiring.
// Backpressure: none; button inputs are levels and the outputs are held registers.
interface cook_time_entry_if;
    // Debounced button levels and oven-timer status inputs
    logic        btn_min;
    logic        btn_sec;
    logic        btn_clear;
    logic        btn_start;
    logic        preheated;
    logic        done;

    // Cook-time request towards the oven timer plus panel indicators
    logic [12:0] cookTime;
    logic        timeinputdone;
    logic        entry_active;
    logic        alarm;

    // Panel / test side: drives buttons and timer status, observes the request
    modport master (
        output btn_min,
        output btn_sec,
        output btn_clear,
        output btn_start,
        output preheated,
        output done,
        input  cookTime,
        input  timeinputdone,
        input  entry_active,
        input  alarm
    );

    // Controller side
    modport slave (
        input  btn_min,
        input  btn_sec,
        input  btn_clear,
        input  btn_start,
        input  preheated,
        input  done,
        output cookTime,
        output timeinputdone,
        output entry_active,
        output alarm
    );
endinterface

// File: rtl/cook_time_entry.sv
// Front-panel cook-time entry: button edges -> saturating seconds request, arm/cook/alarm sequencing.
// Latency: one cycle from a button edge or done/preheated sample to the registered outputs.
// Backpressure: none; held buttons act once, lower-priority edges in the same cycle are dropped.
module cook_time_entry #(
    parameter int MAX_TIME     = 3599,
    parameter int STEP_SEC     = 10,
    parameter int STEP_MIN     = 60,
    parameter int ALARM_CYCLES = 100
) (
    input  logic             clk,
    input  logic             reset,
    cook_time_entry_if.slave panel
);

    localparam int          CNT_W      = $clog2(ALARM_CYCLES + 1);
    localparam logic [13:0] MAX_W      = 14'(MAX_TIME);
    localparam logic [13:0] STEP_MIN_W = 14'(STEP_MIN);
    localparam logic [13:0] STEP_SEC_W = 14'(STEP_SEC);
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_ARMED,
        S_COOKING,
        S_ALARM
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_CLEAR,
        ACT_START,
        ACT_MIN,
        ACT_SEC
    } act_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Previous button levels; reset to 1 so a button held through reset must be released first
    logic             r_prev_min;
    logic             r_prev_sec;
    logic             r_prev_clear;
    logic             r_prev_start;

    logic             w_edge_min;
    logic             w_edge_sec;
    logic             w_edge_clear;
    logic             w_edge_start;
    act_t             w_act;

    logic [12:0]      r_cook_time;
    logic [12:0]      w_cook_time_nxt;
    logic             r_tid;
    logic             w_tid_nxt;
    logic             r_alarm;
    logic             w_alarm_nxt;
    logic             r_entry_active;
    logic [CNT_W-1:0] r_alarm_cnt;
    logic [CNT_W-1:0] w_alarm_cnt_nxt;

    logic [13:0]      w_step;
    logic [13:0]      w_sum;
    logic [12:0]      w_sum_sat;

    assign w_edge_min   = panel.btn_min   & ~r_prev_min;
    assign w_edge_sec   = panel.btn_sec   & ~r_prev_sec;
    assign w_edge_clear = panel.btn_clear & ~r_prev_clear;
    assign w_edge_start = panel.btn_start & ~r_prev_start;

    // Pick the single action for this cycle: clear > start > min > sec
    always_comb begin
        w_act = ACT_NONE;
        if (w_edge_clear) begin
            w_act = ACT_CLEAR;
        end else if (w_edge_start) begin
            w_act = ACT_START;
        end else if (w_edge_min) begin
            w_act = ACT_MIN;
        end else if (w_edge_sec) begin
            w_act = ACT_SEC;
        end
    end

    // Add the selected step one bit wider than cookTime so the ceiling compare sees the true sum
    always_comb begin
        w_step    = (w_act == ACT_MIN) ? STEP_MIN_W : STEP_SEC_W;
        w_sum     = {1'b0, r_cook_time} + w_step;
        w_sum_sat = (w_sum > MAX_W) ? MAX_W[12:0] : w_sum[12:0];
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_cook_time_nxt = r_cook_time;
        w_tid_nxt       = r_tid;
        w_alarm_nxt     = r_alarm;
        w_alarm_cnt_nxt = r_alarm_cnt;

        case (r_state)
            S_IDLE: begin
                w_cook_time_nxt = '0;
                w_tid_nxt       = 1'b0;
                w_alarm_nxt     = 1'b0;
                if (w_act == ACT_MIN || w_act == ACT_SEC) begin
                    w_cook_time_nxt = w_sum_sat;
                    w_state_nxt     = S_ENTRY;
                end
            end

            S_ENTRY: begin
                case (w_act)
                    ACT_CLEAR: begin
                        w_cook_time_nxt = '0;
                        w_state_nxt     = S_IDLE;
                    end
                    ACT_START: begin
                        // An empty request is never handed to the timer
                        if (r_cook_time != '0) begin
                            w_tid_nxt   = 1'b1;
                            w_state_nxt = S_ARMED;
                        end
                    end
                    ACT_MIN, ACT_SEC: begin
                        w_cook_time_nxt = w_sum_sat;
                    end
                    default: begin
                    end
                endcase
            end

            S_ARMED: begin
                if (w_act == ACT_CLEAR) begin
                    w_tid_nxt       = 1'b0;
                    w_cook_time_nxt = '0;
                    w_state_nxt     = S_IDLE;
                end else if (panel.preheated) begin
                    w_state_nxt = S_COOKING;
                end
            end

            S_COOKING: begin
                // Completion outranks a simultaneous cancel so the alarm is never lost
                if (panel.done) begin
                    w_tid_nxt       = 1'b0;
                    w_cook_time_nxt = '0;
                    w_alarm_nxt     = 1'b1;
                    w_alarm_cnt_nxt = ALARM_LOAD;
                    w_state_nxt     = S_ALARM;
                end else if (w_act == ACT_CLEAR) begin
                    w_tid_nxt       = 1'b0;
                    w_cook_time_nxt = '0;
                    w_state_nxt     = S_IDLE;
                end else if (!panel.preheated) begin
                    w_state_nxt = S_ARMED;
                end
            end

            S_ALARM: begin
                // Counter holds the remaining high cycles including the current one
                if (w_act != ACT_NONE || r_alarm_cnt <= CNT_ONE) begin
                    w_alarm_nxt     = 1'b0;
                    w_alarm_cnt_nxt = '0;
                    w_cook_time_nxt = '0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_alarm_cnt_nxt = r_alarm_cnt - CNT_ONE;
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_cook_time_nxt = '0;
                w_tid_nxt       = 1'b0;
                w_alarm_nxt     = 1'b0;
                w_alarm_cnt_nxt = '0;
            end
        endcase
    end

    // State, edge-history and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_prev_min     <= 1'b1;
            r_prev_sec     <= 1'b1;
            r_prev_clear   <= 1'b1;
            r_prev_start   <= 1'b1;
            r_cook_time    <= '0;
            r_tid          <= 1'b0;
            r_alarm        <= 1'b0;
            r_alarm_cnt    <= '0;
            r_entry_active <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_prev_min     <= panel.btn_min;
            r_prev_sec     <= panel.btn_sec;
            r_prev_clear   <= panel.btn_clear;
            r_prev_start   <= panel.btn_start;
            r_cook_time    <= w_cook_time_nxt;
            r_tid          <= w_tid_nxt;
            r_alarm        <= w_alarm_nxt;
            r_alarm_cnt    <= w_alarm_cnt_nxt;
            r_entry_active <= (w_state_nxt == S_ENTRY);
        end
    end

    assign panel.cookTime      = r_cook_time;
    assign panel.timeinputdone = r_tid;
    assign panel.alarm         = r_alarm;
    assign panel.entry_active  = r_entry_active;

endmodule

// File: tb/tb_cook_time_entry.sv
// Self-checking bench for cook_time_entry: expectations queued at drive time, compared after each edge.
// Latency: outputs sampled 1 time unit after every rising clock edge.
// Backpressure: none; stimulus is level-driven buttons and timer status.
module tb_cook_time_entry;

    logic clk;
    logic reset;

    cook_time_entry_if ifc ();

    cook_time_entry dut (
        .clk   (clk),
        .reset (reset),
        .panel (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [12:0] cook;
        logic        use_cook;
        logic        tid;
        logic        ea;
        logic        al;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the registered outputs
    int   m_cook     = 0;
    logic m_use_cook = 1'b1;
    logic m_tid      = 1'b0;
    logic m_ea       = 1'b0;
    logic m_al       = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 3599) ? 3599 : v;
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag      = tag;
        e.cook     = 13'(m_cook);
        e.use_cook = m_use_cook;
        e.tid      = m_tid;
        e.ea       = m_ea;
        e.al       = m_al;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare every queued expectation against the outputs
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.use_cook)
                check_val({e.tag, ".cookTime"}, 32'(ifc.cookTime), 32'(e.cook));
            check_val({e.tag, ".timeinputdone"}, 32'(ifc.timeinputdone), 32'(e.tid));
            check_val({e.tag, ".entry_active"}, 32'(ifc.entry_active), 32'(e.ea));
            check_val({e.tag, ".alarm"}, 32'(ifc.alarm), 32'(e.al));
        end
    endtask

    task automatic step(input string tag);
        push_exp(tag);
        cycle();
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: ifc.btn_min   = v;
            1: ifc.btn_sec   = v;
            2: ifc.btn_clear = v;
            default: ifc.btn_start = v;
        endcase
    endtask

    // Press then release; the caller has already moved the model to the post-press values
    task automatic press(input int b, input string tag);
        set_btn(b, 1'b1);
        step(tag);
        set_btn(b, 1'b0);
        step({tag, "_rel"});
    endtask

    task automatic model_add(input int s);
        m_cook = sat(m_cook + s);
        m_ea   = 1'b1;
    endtask

    task automatic model_idle();
        m_cook     = 0;
        m_use_cook = 1'b1;
        m_tid      = 1'b0;
        m_ea       = 1'b0;
        m_al       = 1'b0;
    endtask

    initial begin
        ifc.btn_min   = 1'b1;
        ifc.btn_sec   = 1'b0;
        ifc.btn_clear = 1'b0;
        ifc.btn_start = 1'b0;
        ifc.preheated = 1'b0;
        ifc.done      = 1'b0;
        reset         = 1'b1;

        // Reset values, with btn_min held through reset
        #2;
        check_val("rst.cookTime", 32'(ifc.cookTime), 32'd0);
        check_val("rst.timeinputdone", 32'(ifc.timeinputdone), 32'd0);
        check_val("rst.entry_active", 32'(ifc.entry_active), 32'd0);
        check_val("rst.alarm", 32'(ifc.alarm), 32'd0);
        #20;
        reset = 1'b0;
        model_idle();
        step("held_min");
        ifc.btn_min = 1'b0;
        step("release_min");

        // 60 + 60 + 10 = 130
        model_add(60);
        press(0, "min1");
        model_add(60);
        press(0, "min2");
        model_add(10);
        press(1, "sec1");

        // Clear to IDLE, then start with nothing entered is ignored
        model_idle();
        press(2, "clear130");
        press(3, "start_empty");

        // Saturation at 3599 from repeated minute presses
        for (int i = 0; i < 60; i++) begin
            model_add(60);
            press(0, $sformatf("sat_min%0d", i));
        end
        model_add(10);
        press(1, "sat_sec");
        m_tid = 1'b1;
        m_ea  = 1'b0;
        press(3, "start_full");
        press(0, "armed_min_ignored");
        model_idle();
        press(2, "armed_clear");

        // Same-cycle clear+start in ENTRY with 50: clear wins
        for (int i = 0; i < 5; i++) begin
            model_add(10);
            press(1, $sformatf("fifty%0d", i));
        end
        ifc.btn_clear = 1'b1;
        ifc.btn_start = 1'b1;
        model_idle();
        step("clear_start");
        ifc.btn_clear = 1'b0;
        ifc.btn_start = 1'b0;
        step("clear_start_rel");

        // Arm 30, preheat, done -> alarm for exactly 100 cycles
        for (int i = 0; i < 3; i++) begin
            model_add(10);
            press(1, $sformatf("thirty%0d", i));
        end
        m_tid = 1'b1;
        m_ea  = 1'b0;
        press(3, "start30");
        ifc.preheated = 1'b1;
        step("preheat_on");
        ifc.done   = 1'b1;
        m_tid      = 1'b0;
        m_al       = 1'b1;
        m_use_cook = 1'b0;
        step("done");
        ifc.done      = 1'b0;
        ifc.preheated = 1'b0;
        for (int i = 1; i < 100; i++) step($sformatf("alarm_hi%0d", i));
        model_idle();
        step("alarm_end");
        // IDLE again: a sec press starts a fresh entry
        model_add(10);
        press(1, "after_alarm_sec");

        // Cooking with preheated dropping returns to ARMED; done then ignored
        model_add(10);
        press(1, "c2_sec1");
        model_add(10);
        press(1, "c2_sec2");
        m_tid = 1'b1;
        m_ea  = 1'b0;
        press(3, "c2_start");
        ifc.preheated = 1'b1;
        step("c2_cook");
        ifc.preheated = 1'b0;
        step("c2_back_armed");
        ifc.done = 1'b1;
        step("c2_done_in_armed");
        ifc.done      = 1'b0;
        ifc.preheated = 1'b1;
        step("c2_cook_again");
        ifc.done   = 1'b1;
        m_tid      = 1'b0;
        m_al       = 1'b1;
        m_use_cook = 1'b0;
        step("c2_done");
        ifc.done      = 1'b0;
        ifc.preheated = 1'b0;
        step("c2_alarm2");
        step("c2_alarm3");

        // Asynchronous reset mid-alarm
        #3;
        reset = 1'b1;
        #1;
        check_val("arst.cookTime", 32'(ifc.cookTime), 32'd0);
        check_val("arst.timeinputdone", 32'(ifc.timeinputdone), 32'd0);
        check_val("arst.entry_active", 32'(ifc.entry_active), 32'd0);
        check_val("arst.alarm", 32'(ifc.alarm), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_idle();
        step("post_arst");

        // Alarm silenced by a sec press on its 5th cycle
        model_add(10);
        press(1, "s_sec");
        m_tid = 1'b1;
        m_ea  = 1'b0;
        press(3, "s_start");
        ifc.preheated = 1'b1;
        step("s_cook");
        ifc.done   = 1'b1;
        m_tid      = 1'b0;
        m_al       = 1'b1;
        m_use_cook = 1'b0;
        step("s_alarm1");
        ifc.done = 1'b0;
        for (int i = 2; i <= 4; i++) step($sformatf("s_alarm%0d", i));
        model_idle();
        press(1, "s_silence");
        ifc.preheated = 1'b0;
        model_add(10);
        press(1, "s_idle_sec");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
